// File: rtl/text_cfg_pkg.sv
// Shared configuration for the text message path: sizes, blank code, FSM states
// and the fixed message table copied into the character buffer.
package text_cfg_pkg;

  localparam int unsigned MSG_NUM     = 8;
  localparam int unsigned MSG_MAX_LEN = 64;
  localparam int unsigned CHAR_W      = 7;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned ID_W        = $clog2(MSG_NUM);
  localparam int unsigned IDX_W       = $clog2(MSG_MAX_LEN) + 1;

  localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h20;
  localparam logic [CHAR_W-1:0] CHAR_NUL   = 7'h00;
  localparam logic [CHAR_W-1:0] CHAR_NL    = 7'h0A;

  // Out-of-range id latched at reset so the power-up copy finds no message.
  localparam logic [ID_W:0] ID_NONE = MSG_NUM[ID_W:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COPY,
    ST_DONE
  } text_msg_state_t;

  localparam logic [CHAR_W-1:0] MSG_ROM [MSG_NUM][MSG_MAX_LEN] = '{
    // 0: "HI"
    '{0: 7'h48, 1: 7'h49, default: 7'h00},
    // 1: "OK"
    '{0: 7'h4F, 1: 7'h4B, default: 7'h00},
    // 2: "A\nB"
    '{0: 7'h41, 1: 7'h0A, 2: 7'h42, default: 7'h00},
    // 3: 64 x 'X' with no terminator
    '{default: 7'h58},
    // 4: "GAME\nOVER"
    '{0: 7'h47, 1: 7'h41, 2: 7'h4D, 3: 7'h45, 4: 7'h0A,
      5: 7'h4F, 6: 7'h56, 7: 7'h45, 8: 7'h52, default: 7'h00},
    // 5: 16 newlines then "W" (row wraps back to the top)
    '{0: 7'h0A, 1: 7'h0A, 2: 7'h0A, 3: 7'h0A, 4: 7'h0A, 5: 7'h0A,
      6: 7'h0A, 7: 7'h0A, 8: 7'h0A, 9: 7'h0A, 10: 7'h0A, 11: 7'h0A,
      12: 7'h0A, 13: 7'h0A, 14: 7'h0A, 15: 7'h0A, 16: 7'h57, default: 7'h00},
    // 6: "0123456789ABCDEFGH" (column wraps into row 1)
    '{0: 7'h30, 1: 7'h31, 2: 7'h32, 3: 7'h33, 4: 7'h34, 5: 7'h35,
      6: 7'h36, 7: 7'h37, 8: 7'h38, 9: 7'h39, 10: 7'h41, 11: 7'h42,
      12: 7'h43, 13: 7'h44, 14: 7'h45, 15: 7'h46, 16: 7'h47, 17: 7'h48,
      default: 7'h00},
    // 7: empty message
    '{default: 7'h00}
  };

endpackage

// File: rtl/text_msg_rom.sv
// Combinational message ROM lookup; any out-of-range id or index reads as a terminator.
module text_msg_rom
  import text_cfg_pkg::*;
(
  input  logic [ID_W:0]      msg_id,
  input  logic [IDX_W-1:0]   idx,
  output logic [CHAR_W-1:0]  char_c
);

  always_comb begin
    char_c = CHAR_NUL;
    if ((int'(msg_id) < MSG_NUM) && (int'(idx) < MSG_MAX_LEN)) begin
      char_c = MSG_ROM[msg_id[ID_W-1:0]][idx[IDX_W-2:0]];
    end
  end

endmodule

// File: rtl/text_msg_ctl.sv
// Owns the 16x16 character buffer: clears it and copies a ROM message on request,
// and serves the drawer's {row,col} reads with one cycle of latency.
module text_msg_ctl
  import text_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_req,
  input  logic [ID_W-1:0]   msg_id,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CHAR_W-1:0] char_code
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(MSG_MAX_LEN);

  text_msg_state_t   state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [3:0]        row, row_nxt;
  logic [3:0]        col, col_nxt;
  logic [ID_W:0]     id_q, id_nxt;

  logic              we;
  logic [ADDR_W-1:0] we_addr;
  logic [CHAR_W-1:0] we_data;
  logic [CHAR_W-1:0] rom_char;

  logic [CHAR_W-1:0] text_ram [2**ADDR_W];

  text_msg_rom u_rom (
    .msg_id (id_q),
    .idx    (idx),
    .char_c (rom_char)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      wr_addr <= '0;
      idx     <= '0;
      row     <= '0;
      col     <= '0;
      id_q    <= ID_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_addr <= wr_addr_nxt;
      idx     <= idx_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      id_q    <= id_nxt;
      busy    <= (state_nxt == ST_CLEAR) || (state_nxt == ST_COPY);
      done    <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    idx_nxt     = idx;
    row_nxt     = row;
    col_nxt     = col;
    id_nxt      = id_q;
    we          = 1'b0;
    we_addr     = wr_addr;
    we_data     = BLANK_CHAR;

    case (state)
      ST_IDLE: begin
        if (msg_req) begin
          id_nxt      = {1'b0, msg_id};
          wr_addr_nxt = '0;
          state_nxt   = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        we          = 1'b1;
        wr_addr_nxt = wr_addr + ADDR_W'(1);
        if (wr_addr == ADDR_LAST) begin
          idx_nxt   = '0;
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = ST_COPY;
        end
      end

      ST_COPY: begin
        if (rom_char == CHAR_NUL) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
          if (rom_char == CHAR_NL) begin
            row_nxt = row + 4'd1;
            col_nxt = '0;
          end else begin
            we      = 1'b1;
            we_addr = {row, col};
            we_data = rom_char;
            col_nxt = col + 4'd1;
            if (col == 4'hF) row_nxt = row + 4'd1;
          end
          // Unterminated messages stop after the last allowed character.
          if (idx_nxt == IDX_END) state_nxt = ST_DONE;
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Buffer write port; the read below sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (we) text_ram[we_addr] <= we_data;
  end

  always_ff @(posedge clk) begin
    if (rst) char_code <= '0;
    else     char_code <= text_ram[char_xy];
  end

endmodule
